// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared SPI mode constants and slave FSM state type
package spi_slave_pkg;

    localparam bit CPOL      = 1'b0;
    localparam bit CPHA      = 1'b0;
    localparam bit MSB_FIRST = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - N-flop input synchronizer with parameterised reset value
module spi_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {N{RST_VAL}};
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 MSB-first byte slave oversampled in the clk domain
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_TX     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_abort
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int RST_W = $clog2(SYNC_STAGES + 1);

    logic sclk_s, ss_n_s, mosi_s;
    logic sclk_prev_q, ss_n_prev_q;
    logic armed_q;
    logic [RST_W-1:0] rst_cnt_q;
    logic sclk_rise, sclk_fall, ss_fall, ss_rise;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              tx_ready_q, tx_ready_d;
    logic [DATA_W-2:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              miso_q, miso_d, miso_oe_q, miso_oe_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_underrun_q, tx_underrun_d;
    logic              frame_abort_q, frame_abort_d;
    logic              reload;
    logic [DATA_W-1:0] rx_byte;

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(sclk), .q_o(sclk_s));
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss_n (
        .clk(clk), .rst_n(rst_n), .d_i(ss_n), .q_o(ss_n_s));
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d_i(mosi), .q_o(mosi_s));

    // A frame may only start once the synchronizer carries real input and ss_n has been seen high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev_q <= 1'b0;
            ss_n_prev_q <= 1'b1;
            rst_cnt_q   <= '0;
            armed_q     <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
            ss_n_prev_q <= ss_n_s;
            if (rst_cnt_q != RST_W'(SYNC_STAGES)) begin
                rst_cnt_q <= rst_cnt_q + RST_W'(1);
            end
            if (rst_cnt_q == RST_W'(SYNC_STAGES) && ss_n_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_fall   = armed_q & ss_n_prev_q & ~ss_n_s;
    assign ss_rise   = ss_n_s & ~ss_n_prev_q;
    assign rx_byte   = {rx_shift_q, mosi_s};

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        hold_d        = hold_q;
        tx_ready_d    = tx_ready_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        miso_d        = miso_q;
        miso_oe_d     = miso_oe_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        frame_abort_d = 1'b0;
        reload        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d   = ACTIVE;
                    miso_oe_d = 1'b1;
                    bit_cnt_d = '0;
                    reload    = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d   = IDLE;
                    miso_oe_d = 1'b0;
                    miso_d    = 1'b0;
                    if (bit_cnt_q != '0) begin
                        frame_abort_d = 1'b1;
                    end
                end else if (sclk_rise) begin
                    rx_shift_d = rx_byte[DATA_W-2:0];
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        bit_cnt_d  = '0;
                        rx_data_d  = rx_byte;
                        rx_valid_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q == '0) begin
                        reload = 1'b1;
                    end else begin
                        miso_d     = tx_shift_q[DATA_W-2];
                        tx_shift_d = {tx_shift_q[DATA_W-3:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // miso_q holds the byte MSB; tx_shift_q holds the bits still to follow
        if (reload) begin
            if (!tx_ready_q) begin
                {miso_d, tx_shift_d} = hold_q;
                tx_ready_d           = 1'b1;
            end else begin
                {miso_d, tx_shift_d} = IDLE_TX;
                tx_underrun_d        = 1'b1;
            end
        end

        if (tx_load && tx_ready_q) begin
            hold_d     = tx_data;
            tx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            hold_q        <= '0;
            tx_ready_q    <= 1'b1;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            hold_q        <= hold_d;
            tx_ready_q    <= tx_ready_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - scoreboard bench driving spi_slave as a mode-0 SPI master
module tb_spi_slave;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       tx_load = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_abort;
    logic [7:0] rx_data;

    int n_tests = 0;
    int n_fail = 0;
    int rxv_cnt = 0;
    int und_cnt = 0;
    int abort_cnt = 0;
    int und_at_start = 0;
    int u0, v0, a0;

    logic [7:0] m_tx[$];
    logic [7:0] mrx_exp[$];
    logic [7:0] rx_exp[$];
    logic [7:0] auto_tx[$];

    spi_slave dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            check("rx_pending", 32'(rx_exp.size() > 0), 32'd1);
            if (rx_exp.size() > 0) check("rx_data", 32'(rx_data), 32'(rx_exp.pop_front()));
        end
        if (tx_underrun) und_cnt++;
        if (frame_abort) abort_cnt++;
    end

    task automatic load(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        tick(1);
    endtask

    task automatic spi_frame(input int nbits, input bit keep_ss);
        logic [7:0] r;
        logic [7:0] b;
        r = 8'h00;
        ss_n = 1'b0;
        tick(2 * H);
        und_at_start = und_cnt;
        for (int i = 0; i < nbits; i++) begin
            b = m_tx[i / 8];
            mosi = b[7 - (i % 8)];
            tick(H);
            r = {r[6:0], miso};
            sclk = 1'b1;
            tick(H);
            sclk = 1'b0;
            if (i % 8 == 7) begin
                if (mrx_exp.size() > 0) check("miso_byte", 32'(r), 32'(mrx_exp.pop_front()));
                else check("miso_pending", 32'(mrx_exp.size()), 32'd1);
                if (auto_tx.size() > 0) begin
                    tx_data = auto_tx.pop_front();
                    tx_load = 1'b1;
                    tick(1);
                    tx_load = 1'b0;
                end
            end
        end
        m_tx.delete();
        if (!keep_ss) begin
            tick(H);
            ss_n = 1'b1;
            mosi = 1'b0;
            tick(2 * H + 4);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, 32'(miso), 32'd0);
        check({tag, "_miso_oe"}, 32'(miso_oe), 32'd0);
        check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_underrun"}, 32'(tx_underrun), 32'd0);
        check({tag, "_abort"}, 32'(frame_abort), 32'd0);
    endtask

    initial begin
        tick(3);
        check_reset_outputs("rst0");
        rst_n = 1'b1;
        tick(6);

        // 1: single byte with a preloaded reply
        load(8'h3C);
        check("t1_ready_loaded", 32'(tx_ready), 32'd0);
        m_tx.push_back(8'hA5); rx_exp.push_back(8'hA5); mrx_exp.push_back(8'h3C);
        u0 = und_cnt; v0 = rxv_cnt;
        spi_frame(8, 1'b0);
        check("t1_und_start", 32'(und_at_start - u0), 32'd0);
        check("t1_rxv", 32'(rxv_cnt - v0), 32'd1);
        check("t1_tx_ready", 32'(tx_ready), 32'd1);
        check("t1_rx_data", 32'(rx_data), 32'hA5);
        check("t1_oe_off", 32'(miso_oe), 32'd0);

        // 2: three bytes, replies loaded as each byte completes
        load(8'h11);
        auto_tx.push_back(8'h22); auto_tx.push_back(8'h33);
        m_tx.push_back(8'h01); m_tx.push_back(8'h80); m_tx.push_back(8'hFF);
        rx_exp.push_back(8'h01); rx_exp.push_back(8'h80); rx_exp.push_back(8'hFF);
        mrx_exp.push_back(8'h11); mrx_exp.push_back(8'h22); mrx_exp.push_back(8'h33);
        v0 = rxv_cnt;
        spi_frame(24, 1'b0);
        check("t2_rxv", 32'(rxv_cnt - v0), 32'd3);
        check("t2_miso_left", 32'(mrx_exp.size()), 32'd0);

        // 3: underrun at frame start
        m_tx.push_back(8'h5A); rx_exp.push_back(8'h5A); mrx_exp.push_back(8'h00);
        u0 = und_cnt;
        spi_frame(8, 1'b0);
        check("t3_und_start", 32'(und_at_start - u0), 32'd1);
        check("t3_rx_data", 32'(rx_data), 32'h5A);

        // 4: abort after four bits
        m_tx.push_back(8'hF0);
        a0 = abort_cnt; v0 = rxv_cnt;
        spi_frame(4, 1'b0);
        check("t4_abort", 32'(abort_cnt - a0), 32'd1);
        check("t4_rxv", 32'(rxv_cnt - v0), 32'd0);
        check("t4_rx_data", 32'(rx_data), 32'h5A);
        check("t4_oe", 32'(miso_oe), 32'd0);

        // 5: reset mid-byte, ss_n held low across release, then a clean frame
        m_tx.push_back(8'hFF);
        v0 = rxv_cnt;
        spi_frame(5, 1'b1);
        rst_n = 1'b0;
        tick(2);
        check_reset_outputs("t5_rst");
        rst_n = 1'b1;
        tick(2);
        mosi = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sclk = 1'b1; tick(H);
            sclk = 1'b0; tick(H);
        end
        check("t5_wait_oe", 32'(miso_oe), 32'd0);
        check("t5_wait_rxv", 32'(rxv_cnt - v0), 32'd0);
        ss_n = 1'b1; mosi = 1'b0;
        tick(8);
        m_tx.push_back(8'hC3); rx_exp.push_back(8'hC3); mrx_exp.push_back(8'h00);
        spi_frame(8, 1'b0);
        check("t5_rx_data", 32'(rx_data), 32'hC3);

        // 6: second load while full is dropped
        load(8'h96);
        check("t6_ready0", 32'(tx_ready), 32'd0);
        load(8'h69);
        m_tx.push_back(8'h42); rx_exp.push_back(8'h42); mrx_exp.push_back(8'h96);
        spi_frame(8, 1'b0);
        check("t6_ready_after", 32'(tx_ready), 32'd1);
        check("t6_rx_data", 32'(rx_data), 32'h42);

        check("rx_leftover", 32'(rx_exp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
